// File: rtl/alu_pool_pipelined_if.sv
// Requester bundle between SIC ports and the ALU pool: per-port request
// with tag, and per-port one-cycle response pulse.
interface alu_pool_pipelined_if #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 8,
    parameter int DATA_W    = 16
);
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic [2:0]               op;
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } alu_req_t;

    typedef logic signed [DATA_W-1:0] alu_ans_t;

    logic [NUM_PORTS-1:0] req_valid;
    alu_req_t             req        [NUM_PORTS];
    logic [TAG_W-1:0]     req_tag    [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] resp_valid;
    alu_ans_t             resp_ans   [NUM_PORTS];
    logic [TAG_W-1:0]     resp_tag   [NUM_PORTS];
    logic [UNIT_W-1:0]    resp_unit  [NUM_PORTS];

    modport master (
        output req_valid, req, req_tag,
        input  req_ready, resp_valid, resp_ans, resp_tag, resp_unit
    );

    modport slave (
        input  req_valid, req, req_tag,
        output req_ready, resp_valid, resp_ans, resp_tag, resp_unit
    );
endinterface

// File: rtl/alu_pool_pipelined.sv
// Pool of fixed-latency pipelined ALUs shared by several requester ports.
// Round-robin port scan, lowest free enabled unit per granted port.
module alu_pool_pipelined #(
    parameter int NUM_UNITS = 4,
    parameter int NUM_PORTS = 4,
    parameter int LATENCY   = 2,
    parameter int TAG_W     = 8,
    parameter int DATA_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_UNITS-1:0]           unit_en,
    alu_pool_pipelined_if.slave            bus,
    output logic [$clog2(NUM_UNITS+1)-1:0] busy_units
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int BUSY_W = $clog2(NUM_UNITS+1);
    localparam int SH_W   = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_SADD = 3'd5, OP_SHL = 3'd6, OP_SRA = 3'd7;

    localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

    typedef logic signed [DATA_W-1:0] data_t;

    function automatic data_t sat(input logic signed [DATA_W:0] x);
        if (x > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (x < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                  sat = x[DATA_W-1:0];
    endfunction

    function automatic data_t alu(input logic [2:0] op, input data_t a, input data_t b);
        logic signed [DATA_W:0] wide;
        wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SADD: alu = sat(wide);
            OP_SHL:  alu = a <<< b[SH_W-1:0];
            default: alu = a >>> b[SH_W-1:0];
        endcase
    endfunction

    logic [PORT_W-1:0]    r_rr_ptr;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [BUSY_W-1:0]    w_busy;
    logic [PORT_W-1:0]    w_last;
    logic [NUM_UNITS-1:0] w_vld_p0;
    logic [PORT_W-1:0]    w_own_p0 [NUM_UNITS];
    logic [TAG_W-1:0]     w_tag_p0 [NUM_UNITS];
    data_t                w_ans_p0 [NUM_UNITS];

    logic [NUM_UNITS-1:0] w_vld_last;
    logic [PORT_W-1:0]    w_own_last [NUM_UNITS];
    logic [TAG_W-1:0]     w_tag_last [NUM_UNITS];
    data_t                w_ans_last [NUM_UNITS];

    logic [NUM_PORTS-1:0] w_rsp_vld, r_rsp_vld;
    data_t                w_rsp_ans  [NUM_PORTS], r_rsp_ans  [NUM_PORTS];
    logic [TAG_W-1:0]     w_rsp_tag  [NUM_PORTS], r_rsp_tag  [NUM_PORTS];
    logic [UNIT_W-1:0]    w_rsp_unit [NUM_PORTS], r_rsp_unit [NUM_PORTS];

    // Stage 0: allocation and combinational ALU
    always_comb begin : alloc
        logic [NUM_UNITS-1:0] w_free;
        logic [PORT_W:0]      w_sum;
        logic [PORT_W-1:0]    w_idx;
        logic                 w_hit;
        w_gnt    = '0;
        w_busy   = '0;
        w_last   = r_rr_ptr;
        w_vld_p0 = '0;
        w_free   = unit_en;
        w_sum    = '0;
        w_idx    = '0;
        w_hit    = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) w_own_p0[u] = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_sum = {1'b0, r_rr_ptr} + (PORT_W+1)'(i);
                if (w_sum >= (PORT_W+1)'(NUM_PORTS)) w_sum = w_sum - (PORT_W+1)'(NUM_PORTS);
                w_idx = w_sum[PORT_W-1:0];
                w_hit = 1'b0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (bus.req_valid[w_idx] && w_free[u] && !w_hit) begin
                        w_hit        = 1'b1;
                        w_free[u]    = 1'b0;
                        w_vld_p0[u]  = 1'b1;
                        w_own_p0[u]  = w_idx;
                        w_gnt[w_idx] = 1'b1;
                        w_busy       = w_busy + BUSY_W'(1);
                        w_last       = w_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_tag_p0[u] = bus.req_tag[w_own_p0[u]];
            w_ans_p0[u] = alu(bus.req[w_own_p0[u]].op, bus.req[w_own_p0[u]].a,
                              bus.req[w_own_p0[u]].b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (|w_gnt)
            r_rr_ptr <= (w_last == PORT_W'(NUM_PORTS-1)) ? '0 : w_last + 1'b1;
    end

    // Stages 1..LATENCY-1: per-unit pipeline registers
    generate
        if (LATENCY > 1) begin : g_pipe
            localparam int D = LATENCY - 1;
            logic [NUM_UNITS-1:0] r_vld_p [D];
            logic [PORT_W-1:0]    r_own_p [D][NUM_UNITS];
            logic [TAG_W-1:0]     r_tag_p [D][NUM_UNITS];
            data_t                r_ans_p [D][NUM_UNITS];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    for (int s = 0; s < D; s++) r_vld_p[s] <= '0;
                end else begin
                    r_vld_p[0] <= w_vld_p0;
                    for (int s = 1; s < D; s++) r_vld_p[s] <= r_vld_p[s-1];
                end
            end

            always_ff @(posedge clk) begin
                r_own_p[0] <= w_own_p0;
                r_tag_p[0] <= w_tag_p0;
                r_ans_p[0] <= w_ans_p0;
                for (int s = 1; s < D; s++) begin
                    r_own_p[s] <= r_own_p[s-1];
                    r_tag_p[s] <= r_tag_p[s-1];
                    r_ans_p[s] <= r_ans_p[s-1];
                end
            end

            assign w_vld_last = r_vld_p[D-1];
            assign w_own_last = r_own_p[D-1];
            assign w_tag_last = r_tag_p[D-1];
            assign w_ans_last = r_ans_p[D-1];
        end else begin : g_nopipe
            assign w_vld_last = w_vld_p0;
            assign w_own_last = w_own_p0;
            assign w_tag_last = w_tag_p0;
            assign w_ans_last = w_ans_p0;
        end
    endgenerate

    // Final stage: route each unit's result back to its owner port
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rsp_vld[p]  = 1'b0;
            w_rsp_ans[p]  = '0;
            w_rsp_tag[p]  = '0;
            w_rsp_unit[p] = '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_vld_last[u] && w_own_last[u] == PORT_W'(p)) begin
                    w_rsp_vld[p]  = 1'b1;
                    w_rsp_ans[p]  = w_ans_last[u];
                    w_rsp_tag[p]  = w_tag_last[u];
                    w_rsp_unit[p] = UNIT_W'(u);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) r_rsp_vld <= '0;
        else              r_rsp_vld <= w_rsp_vld;
    end

    always_ff @(posedge clk) begin
        r_rsp_ans  <= w_rsp_ans;
        r_rsp_tag  <= w_rsp_tag;
        r_rsp_unit <= w_rsp_unit;
    end

    // Flush and reset mask the output pulse in the same cycle they are raised
    assign bus.req_ready  = w_gnt;
    assign bus.resp_valid = r_rsp_vld & {NUM_PORTS{!(rst || flush)}};
    assign busy_units     = w_busy;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.resp_ans[p]  = bus.resp_valid[p] ? r_rsp_ans[p]  : '0;
            bus.resp_tag[p]  = bus.resp_valid[p] ? r_rsp_tag[p]  : '0;
            bus.resp_unit[p] = bus.resp_valid[p] ? r_rsp_unit[p] : '0;
        end
    end
endmodule

// File: tb/tb_alu_pool_pipelined.sv
// Randomised scoreboard bench for the ALU pool, with directed scenarios first.
module tb_alu_pool_pipelined;
    localparam int NU = 4, NP = 4, LAT = 2, TW = 8, DW = 16, UW = 2;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [NU-1:0] unit_en;
    logic [$clog2(NU+1)-1:0] busy_units;

    alu_pool_pipelined_if #(.NUM_PORTS(NP), .NUM_UNITS(NU), .TAG_W(TW), .DATA_W(DW)) bus ();

    alu_pool_pipelined #(.NUM_UNITS(NU), .NUM_PORTS(NP), .LATENCY(LAT), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .unit_en(unit_en), .bus(bus), .busy_units(busy_units)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] ans;
        logic [TW-1:0] tag;
        logic [UW-1:0] unit;
    } exp_t;

    exp_t          sb [NP][$];
    int            n_chk = 0, n_fail = 0, cyc = 0, m_rr = 0;
    logic [NP-1:0] exp_gnt = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int sa, sb2, r;
        sa  = int'($signed(a));
        sb2 = int'($signed(b));
        case (op)
            3'd0: r = sa + sb2;
            3'd1: r = sa - sb2;
            3'd2: r = sa & sb2;
            3'd3: r = sa | sb2;
            3'd4: r = sa ^ sb2;
            3'd5: begin
                r = sa + sb2;
                if (r > 32767) r = 32767;
                else if (r < -32768) r = -32768;
            end
            3'd6: r = sa << b[3:0];
            default: r = sa >>> b[3:0];
        endcase
        return r[DW-1:0];
    endfunction

    // Monitor: compares every port's output against the scoreboard head
    always @(negedge clk) begin : mon
        exp_t x;
        int   e;
        e = cyc + 1;
        for (int p = 0; p < NP; p++) begin
            if (rst || flush) begin
                check($sformatf("quiet_valid[%0d]", p), bus.resp_valid[p], 0);
                check($sformatf("quiet_ans[%0d]", p), $unsigned(bus.resp_ans[p]), 0);
            end else if (sb[p].size() > 0 && sb[p][0].due == e) begin
                x = sb[p].pop_front();
                check($sformatf("resp_valid[%0d]", p), bus.resp_valid[p], 1);
                check($sformatf("resp_ans[%0d]", p), $unsigned(bus.resp_ans[p]), x.ans);
                check($sformatf("resp_tag[%0d]", p), bus.resp_tag[p], x.tag);
                check($sformatf("resp_unit[%0d]", p), bus.resp_unit[p], x.unit);
            end else begin
                check($sformatf("idle_valid[%0d]", p), bus.resp_valid[p], 0);
                check($sformatf("idle_ans[%0d]", p), $unsigned(bus.resp_ans[p]), 0);
                check($sformatf("idle_tag[%0d]", p), bus.resp_tag[p], 0);
                check($sformatf("idle_unit[%0d]", p), bus.resp_unit[p], 0);
            end
        end
    end

    // Reference model: grants from a free-unit list, responses due LAT edges later
    always @(negedge clk) begin : model
        int            free [$];
        logic [NP-1:0] gnt;
        int            last, nb, e, p, k;
        exp_t          x;
        #1;
        e = cyc + 1;
        gnt = '0;
        last = -1;
        nb = 0;
        free.delete();
        if (!rst && !flush) begin
            for (int u = 0; u < NU; u++) if (unit_en[u]) free.push_back(u);
            for (int i = 0; i < NP; i++) begin
                p = (m_rr + i) % NP;
                if (bus.req_valid[p] && free.size() > 0) begin
                    k      = free.pop_front();
                    gnt[p] = 1'b1;
                    nb++;
                    last   = p;
                    x.due  = e + LAT;
                    x.ans  = ref_alu(bus.req[p].op, bus.req[p].a, bus.req[p].b);
                    x.tag  = bus.req_tag[p];
                    x.unit = k[UW-1:0];
                    sb[p].push_back(x);
                end
            end
        end
        for (int q = 0; q < NP; q++)
            check($sformatf("req_ready[%0d]", q), bus.req_ready[q], gnt[q]);
        check("busy_units", busy_units, nb);
        exp_gnt = gnt;
        if (rst || flush) for (int q = 0; q < NP; q++) sb[q].delete();
        if (rst) m_rr = 0;
        else if (last >= 0) m_rr = (last + 1) % NP;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (exp_gnt[p]) bus.req_valid[p] = 1'b0;
    endtask

    task automatic issue(input int p, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag);
        bus.req[p].op   = op;
        bus.req[p].a    = a;
        bus.req[p].b    = b;
        bus.req_tag[p]  = tag;
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic wait_grant(input int p);
        for (int n = 0; n < 20 && bus.req_valid[p]; n++) step();
        check($sformatf("grant_timeout[%0d]", p), bus.req_valid[p], 0);
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'(($urandom_range(0, 15)));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        unit_en = '1;
        bus.req_valid = '0;
        for (int p = 0; p < NP; p++) issue(p, 3'd0, 16'd0, 16'd0, 8'd0);
        bus.req_valid = '0;
        repeat (3) step();
        rst = 1'b0;

        // Single ADD on port 0
        issue(0, 3'd0, 16'd5, 16'd7, 8'h11);
        @(negedge clk);
        check("add_ready0", bus.req_ready[0], 1);
        step();
        step();
        @(negedge clk);
        check("add_valid0", bus.resp_valid[0], 1);
        check("add_ans0", $unsigned(bus.resp_ans[0]), 12);
        check("add_tag0", bus.resp_tag[0], 8'h11);
        check("add_unit0", bus.resp_unit[0], 0);
        repeat (3) step();

        // Four ports contend for two enabled units
        do_reset();
        unit_en = 4'b0011;
        for (int p = 0; p < NP; p++) issue(p, 3'd1, 16'(100 * p), 16'd3, 8'(8'h40 + p));
        @(negedge clk);
        check("rr_first_ready", bus.req_ready, 4'b0011);
        check("rr_first_busy", busy_units, 2);
        step();
        @(negedge clk);
        check("rr_second_ready", bus.req_ready, 4'b1100);
        check("rr_second_busy", busy_units, 2);
        step();
        unit_en = '1;
        repeat (4) step();

        // Back-to-back issue on port 2
        for (int t = 0; t < 5; t++) begin
            issue(2, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 8'(8'h20 + t));
            step();
            wait_grant(2);
        end
        repeat (4) step();

        // Flush one cycle after issue on ports 0 and 1
        issue(0, 3'd0, 16'd1, 16'd2, 8'h50);
        issue(1, 3'd2, 16'hF0F0, 16'h0FF0, 8'h51);
        step();
        flush = 1'b1;
        issue(2, 3'd4, 16'h1234, 16'h00FF, 8'h52);
        step();
        flush = 1'b0;
        repeat (6) step();

        // Reset with three operations in flight
        issue(0, 3'd5, 16'h7FFF, 16'h0001, 8'h60);
        issue(1, 3'd6, 16'h0003, 16'h0004, 8'h61);
        issue(2, 3'd7, 16'h8000, 16'h0002, 8'h62);
        step();
        rst = 1'b1;
        issue(3, 3'd0, 16'd9, 16'd9, 8'h63);
        step();
        step();
        rst = 1'b0;
        repeat (6) step();

        // Disable unit 0 right after port 0 was issued onto it
        issue(0, 3'd0, 16'd21, 16'd21, 8'h70);
        step();
        unit_en = 4'b1110;
        issue(1, 3'd1, 16'd50, 16'd8, 8'h71);
        @(negedge clk);
        check("disable_ready1", bus.req_ready[1], 1);
        step();
        unit_en = '1;
        repeat (4) step();

        // Random traffic with occasional flush, reset and enable changes
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) unit_en = 4'($urandom_range(0, 15));
            for (int p = 0; p < NP; p++)
                if (!bus.req_valid[p] && $urandom_range(0, 2) == 0)
                    issue(p, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 8'($urandom));
            step();
        end

        flush = 1'b0;
        rst = 1'b0;
        unit_en = '1;
        bus.req_valid = '0;
        repeat (LAT + 4) step();
        for (int p = 0; p < NP; p++) check($sformatf("drain[%0d]", p), sb[p].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pool_pipelined.md
ALU_POOL_PIPELINED -- requirements
Module: alu_pool_pipelined

Interface
REQ-001 The module SHALL have parameter NUM_UNITS, default 4, number of pipelined ALU units.
REQ-002 The module SHALL have parameter NUM_PORTS, default 4, number of requester (SIC) ports.
REQ-003 The module SHALL have parameter LATENCY, default 2, issue-to-response cycles, legal range 1..8.
REQ-004 The module SHALL have parameter TAG_W, default 8, width of the requester tag.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The module SHALL have port flush, input, 1 bit, kill all in-flight operations.
REQ-008 The module SHALL have port unit_en, input, NUM_UNITS bits, per-unit enable mask.
REQ-009 The module SHALL have port req_valid, input, NUM_PORTS x 1 bit, per-port request.
REQ-010 The module SHALL have port req, input, NUM_PORTS x alu_req_t, operation and operands.
REQ-011 The module SHALL have port req_tag, input, NUM_PORTS x TAG_W bits, returned with the result.
REQ-012 The module SHALL have port req_ready, output, NUM_PORTS x 1 bit, request accepted this cycle.
REQ-013 The module SHALL have port resp_valid, output, NUM_PORTS x 1 bit, one-cycle result pulse.
REQ-014 The module SHALL have port resp_ans, output, NUM_PORTS x alu_ans_t, the result.
REQ-015 The module SHALL have port resp_tag, output, NUM_PORTS x TAG_W bits, the tag of the result.
REQ-016 The module SHALL have port resp_unit, output, NUM_PORTS x $clog2(NUM_UNITS) bits, the unit that produced the result.
REQ-017 The module SHALL have port busy_units, output, $clog2(NUM_UNITS+1) bits, count of units issued this cycle.

Function
REQ-018 Each unit SHALL be fully pipelined, accepting one operation per cycle, with the combinational alu at stage 0 and LATENCY-1 register stages after it, and each stage carrying valid, owner port, tag and answer.
REQ-019 Allocation SHALL be combinational each cycle: scan ports from rr_ptr upward with wrap; each port with req_valid=1 gets the lowest-index enabled unit not yet taken this cycle, until enabled units run out.
REQ-020 req_ready[p] SHALL be 1 only if port p was allocated a unit this cycle; the handshake is req_valid&req_ready at the rising edge.
REQ-021 A request not granted SHALL hold req, req_tag and req_valid stable until granted; the module SHALL NOT drop or buffer unaccepted requests.
REQ-022 rr_ptr SHALL update to (last granted port + 1) mod NUM_PORTS when at least one grant occurs; otherwise it holds.
REQ-023 An operation accepted at edge N SHALL produce resp_valid=1 for exactly one cycle at edge N+LATENCY on the issuing port, with its resp_tag and resp_unit.
REQ-024 At most one response SHALL complete per port per cycle, because each port issues at most once per cycle and latency is fixed; no response backpressure exists.
REQ-025 When resp_valid[p]=0, resp_ans[p], resp_tag[p] and resp_unit[p] SHALL be 0.
REQ-026 A disabled unit (unit_en[k]=0) SHALL receive no new grants; operations already in its pipeline SHALL complete normally.
REQ-027 When flush=1 on edge N, all stage valids SHALL clear, no grants SHALL be given in that cycle (req_ready all 0), and no response from pre-flush operations SHALL appear at edge N or later.
REQ-028 busy_units SHALL equal the number of grants issued in the current cycle, 0..min(NUM_UNITS, NUM_PORTS).
REQ-029 If NUM_PORTS > number of enabled units, every continuously requesting port SHALL be granted within ceil(NUM_PORTS/enabled) cycles.

Reset
REQ-030 With rst=1 at an edge, all pipeline valids SHALL clear and rr_ptr SHALL become 0.
REQ-031 While rst=1, req_ready, resp_valid, resp_ans, resp_tag, resp_unit and busy_units SHALL all be 0.
REQ-032 A reset applied mid-operation SHALL discard all in-flight results; none appear after reset deasserts.

Verification
REQ-033 The bench SHALL cover: port0 ADD a=5 b=7 tag=0x11 alone, LATENCY=2 -> req_ready[0]=1 at issue; two cycles later resp_valid[0]=1, ans=12, tag=0x11, unit=0.
REQ-034 The bench SHALL cover: all 4 ports request with unit_en=4'b0011, rr_ptr=0 -> cycle 1 grants ports 0,1 (units 0,1), cycle 2 grants ports 2,3; busy_units=2 both cycles.
REQ-035 The bench SHALL cover: back-to-back issue from port 2 for 5 cycles -> 5 consecutive resp_valid pulses, tags in order, no gaps.
REQ-036 The bench SHALL cover: issue on ports 0 and 1, flush asserted one cycle later -> no resp_valid ever, req_ready=0 during the flush cycle.
REQ-037 The bench SHALL cover: rst asserted while 3 operations are in flight -> all outputs 0, and no responses after rst deasserts.
REQ-038 The bench SHALL cover: unit_en[0] cleared one cycle after port0 issues to unit 0 -> that response still arrives; the next grant goes to unit 1.
